// File: rtl/uart_reg_master_pkg.sv
// Register-port encodings shared by uart_reg_master and uart_top, plus the master FSM state type.
package uart_reg_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KICK,
    ST_WAIT_TX,
    ST_WAIT_RX,
    ST_READ,
    ST_RSP,
    ST_CLEAR
  } state_t;

  localparam logic REG_SEL_DATA = 1'b1;
  localparam logic REG_SEL_CTRL = 1'b0;

  localparam logic [31:0] CTRL_RXEN    = 32'h1;
  localparam logic [31:0] CTRL_TXSTART = 32'h2;
  localparam logic [31:0] CTRL_CLR     = 32'h4;

  localparam int STAT_TXDONE_BIT = 8;
  localparam int STAT_RXDONE_BIT = 9;

  // Control word that starts a transmit, optionally arming the receiver.
  function automatic logic [31:0] kick_word(input logic want_rx);
    return CTRL_TXSTART | (want_rx ? CTRL_RXEN : 32'h0);
  endfunction

endpackage

// File: rtl/uart_cmd_fifo.sv
// Small synchronous command FIFO with first-word-fall-through read; accepts a push while full
// when a pop happens in the same cycle.
module uart_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_reg;
  logic [AW:0]      rptr_reg;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wptr_reg == rptr_reg);
  assign full    = (wptr_reg[AW] != rptr_reg[AW]) && (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign ready   = !full || do_pop;
  assign do_push = push && ready;
  assign dout    = mem[rptr_reg[AW-1:0]];

  always_ff @(posedge Clk) begin
    if (do_push) mem[wptr_reg[AW-1:0]] <= din;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else begin
      if (do_push) wptr_reg <= wptr_reg + 1'b1;
      if (do_pop)  rptr_reg <= rptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_reg_master.sv
// Drives the uart_top register port from a byte command FIFO and returns received bytes.
// Define UART_POLL_TIMEOUT_EN to bound each status-poll state to TIMEOUT_CYCLES cycles.
module uart_reg_master
  import uart_reg_master_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [7:0]  cmd_data_i,
  input  logic        cmd_rsp_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [7:0]  rsp_data_o,
  output logic        reg_sel_o,
  output logic        wr_o,
  output logic [31:0] wdata_o,
  input  logic [31:0] rdata_i,
  output logic        busy_o,
  output logic        timeout_o
);

  state_t     state_reg;
  logic       cur_rsp_reg;
  logic [8:0] fifo_dout;
  logic       fifo_empty;
  logic       tx_done;
  logic       rx_done;
  logic       timeout_hit;
  logic       unused_bits;

  assign tx_done     = rdata_i[STAT_TXDONE_BIT];
  assign rx_done     = rdata_i[STAT_RXDONE_BIT];
  assign busy_o      = (state_reg != ST_IDLE) || !fifo_empty;
  assign unused_bits = ^{rdata_i[31:10], TIMEOUT_CYCLES[0]};

  uart_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .push  (cmd_valid_i),
    .din   ({cmd_rsp_i, cmd_data_i}),
    .pop   (state_reg == ST_IDLE),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .ready (cmd_ready_o)
  );

`ifdef UART_POLL_TIMEOUT_EN
  logic [15:0] poll_cnt_reg;
  logic        poll_clr;

  // Restart the count on every entry into a wait state.
  assign poll_clr    = (state_reg == ST_KICK) || (state_reg == ST_WAIT_TX && tx_done);
  assign timeout_hit = (poll_cnt_reg == 16'(TIMEOUT_CYCLES - 1)) &&
                       ((state_reg == ST_WAIT_TX && !tx_done) ||
                        (state_reg == ST_WAIT_RX && !rx_done));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      poll_cnt_reg <= '0;
      timeout_o    <= 1'b0;
    end else begin
      timeout_o <= timeout_hit;
      if (poll_clr)
        poll_cnt_reg <= '0;
      else if (state_reg == ST_WAIT_TX || state_reg == ST_WAIT_RX)
        poll_cnt_reg <= poll_cnt_reg + 16'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  // Outputs are registered, so each branch sets what the next state drives.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg   <= ST_IDLE;
      cur_rsp_reg <= 1'b0;
      wr_o        <= 1'b0;
      reg_sel_o   <= REG_SEL_CTRL;
      wdata_o     <= '0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
    end else begin
      wr_o <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cur_rsp_reg <= fifo_dout[8];
            wr_o        <= 1'b1;
            reg_sel_o   <= REG_SEL_DATA;
            wdata_o     <= {24'h0, fifo_dout[7:0]};
            state_reg   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          wr_o      <= 1'b1;
          reg_sel_o <= REG_SEL_CTRL;
          wdata_o   <= kick_word(cur_rsp_reg);
          state_reg <= ST_KICK;
        end
        ST_KICK: begin
          wdata_o   <= '0;
          state_reg <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (tx_done && cur_rsp_reg) begin
            state_reg <= ST_WAIT_RX;
          end else if (tx_done || timeout_hit) begin
            wr_o      <= 1'b1;
            wdata_o   <= CTRL_CLR;
            state_reg <= ST_CLEAR;
          end
        end
        ST_WAIT_RX: begin
          if (rx_done) begin
            reg_sel_o <= REG_SEL_DATA;
            state_reg <= ST_READ;
          end else if (timeout_hit) begin
            wr_o      <= 1'b1;
            wdata_o   <= CTRL_CLR;
            state_reg <= ST_CLEAR;
          end
        end
        ST_READ: begin
          rsp_data_o  <= rdata_i[7:0];
          rsp_valid_o <= 1'b1;
          reg_sel_o   <= REG_SEL_CTRL;
          state_reg   <= ST_RSP;
        end
        ST_RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            wr_o        <= 1'b1;
            wdata_o     <= CTRL_CLR;
            state_reg   <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          wdata_o   <= '0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_master.sv
// Bench for uart_reg_master against a behavioural uart_top register model with Tx->Rx loopback.
module tb_uart_reg_master;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [7:0]  cmd_data_i = '0;
  logic        cmd_rsp_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [7:0]  rsp_data_o;
  logic        reg_sel_o;
  logic        wr_o;
  logic [31:0] wdata_o;
  logic [31:0] rdata_i;
  logic        busy_o;
  logic        timeout_o;

  int err_cnt = 0;
  int chk_cnt = 0;

`ifdef UART_POLL_TIMEOUT_EN
  localparam int TB_TIMEOUT = 50;
  localparam int EXP_TMO    = 1;
`else
  localparam int TB_TIMEOUT = 65535;
  localparam int EXP_TMO    = 0;
`endif

  always #5 Clk = ~Clk;

  uart_reg_master #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_data_i  (cmd_data_i),
    .cmd_rsp_i   (cmd_rsp_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .reg_sel_o   (reg_sel_o),
    .wr_o        (wr_o),
    .wdata_o     (wdata_o),
    .rdata_i     (rdata_i),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // uart_top register model: data/ctrl writes, sticky TxDone/RxDone, loopback receive
  int         tx_time  = 8;
  bit         loopback = 1'b1;
  logic [7:0] m_tx_byte, m_rx_byte;
  logic       m_txdone, m_rxdone, m_rxen, m_tx_busy, m_rx_pend;
  int         m_tx_cnt, m_rx_cnt;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_tx_byte <= '0; m_rx_byte <= '0; m_txdone <= 1'b0; m_rxdone <= 1'b0;
      m_rxen <= 1'b0; m_tx_busy <= 1'b0; m_rx_pend <= 1'b0; m_tx_cnt <= 0; m_rx_cnt <= 0;
    end else begin
      if (wr_o && reg_sel_o) m_tx_byte <= wdata_o[7:0];
      if (wr_o && !reg_sel_o && wdata_o[2]) begin
        m_txdone <= 1'b0;
        m_rxdone <= 1'b0;
      end
      if (wr_o && !reg_sel_o && wdata_o[1]) begin
        m_tx_busy <= 1'b1;
        m_tx_cnt  <= tx_time;
        m_rxen    <= wdata_o[0];
      end else if (m_tx_busy) begin
        if (m_tx_cnt == 0) begin
          m_tx_busy <= 1'b0;
          m_txdone  <= 1'b1;
          if (m_rxen && loopback) begin
            m_rx_pend <= 1'b1;
            m_rx_cnt  <= 3;
          end
        end else begin
          m_tx_cnt <= m_tx_cnt - 1;
        end
      end
      if (m_rx_pend) begin
        if (m_rx_cnt == 0) begin
          m_rx_pend <= 1'b0;
          m_rxdone  <= 1'b1;
          m_rx_byte <= m_tx_byte;
        end else begin
          m_rx_cnt <= m_rx_cnt - 1;
        end
      end
    end
  end

  assign rdata_i = reg_sel_o ? {24'h0, m_rx_byte} : {22'h0, m_rxdone, m_txdone, 8'h0};

  // scoreboard
  typedef struct packed {
    logic        sel;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_wr [$];
  logic [7:0] exp_rsp [$];
  wr_t        mon_e;
  logic [7:0] mon_b;
  logic       prev_wr  = 1'b0;
  logic       prev_sel = 1'b0;
  int         tmo_pulses = 0;

  always @(negedge Clk) begin
    if (wr_o) begin
      $display("t=%0t wr sel=%0d data=0x%08h", $time, reg_sel_o, wdata_o);
      check_val("wr_b2b", 32'(prev_wr && (prev_sel == reg_sel_o)), 32'd0);
      if (exp_wr.size() == 0) begin
        check_val("wr_unexpected", 32'(exp_wr.size()), 32'd1);
      end else begin
        mon_e = exp_wr.pop_front();
        check_val("wr_sel", 32'(reg_sel_o), 32'(mon_e.sel));
        check_val("wr_data", wdata_o, mon_e.data);
      end
    end
    if (rsp_valid_o && rsp_ready_i) begin
      $display("t=%0t rsp data=0x%02h", $time, rsp_data_o);
      if (exp_rsp.size() == 0) begin
        check_val("rsp_unexpected", 32'(exp_rsp.size()), 32'd1);
      end else begin
        mon_b = exp_rsp.pop_front();
        check_val("rsp_data", 32'(rsp_data_o), 32'(mon_b));
      end
    end
    if (timeout_o) tmo_pulses <= tmo_pulses + 1;
    prev_wr  <= wr_o;
    prev_sel <= reg_sel_o;
  end

  task automatic push_cmd(input logic [7:0] b, input logic r);
    bit  done = 1'b0;
    wr_t w;
    @(posedge Clk); #1;
    cmd_valid_i = 1'b1;
    cmd_data_i  = b;
    cmd_rsp_i   = r;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge Clk);
      if (cmd_ready_o) begin
        w.sel = 1'b1; w.data = {24'h0, b};      exp_wr.push_back(w);
        w.sel = 1'b0; w.data = 32'h2 | 32'(r);  exp_wr.push_back(w);
        w.sel = 1'b0; w.data = 32'h4;           exp_wr.push_back(w);
        if (r && loopback) exp_rsp.push_back(b);
        @(posedge Clk); #1;
        cmd_valid_i = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      check_val("push_stall", 32'(cmd_ready_o), 32'd1);
      cmd_valid_i = 1'b0;
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (n < max_cyc && (busy_o || exp_wr.size() != 0)) begin
      @(negedge Clk);
      n++;
    end
    check_val("idle", 32'(busy_o), 32'd0);
    check_val("sb_drain", 32'(exp_wr.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    bit         saw;
    logic [7:0] seq [5];
    seq = '{8'h01, 8'h82, 8'h43, 8'hC4, 8'h25};

    // reset state
    #95;
    check_val("rst_wr", 32'(wr_o), 32'd0);
    check_val("rst_sel", 32'(reg_sel_o), 32'd0);
    check_val("rst_wdata", wdata_o, 32'd0);
    check_val("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check_val("rst_rsp_data", 32'(rsp_data_o), 32'd0);
    check_val("rst_timeout", 32'(timeout_o), 32'd0);
    check_val("rst_ready", 32'(cmd_ready_o), 32'd1);
    check_val("rst_busy", 32'(busy_o), 32'd0);
    #5;
    Rst_n = 1'b1;

    // single transmit, no response
    push_cmd(8'hA5, 1'b0);
    wait_idle(500);

    // loopback response held under backpressure
    rsp_ready_i = 1'b0;
    push_cmd(8'h3C, 1'b1);
    n = 0;
    while (!rsp_valid_o && n < 1000) begin
      @(negedge Clk);
      n++;
    end
    check_val("rsp_seen", 32'(rsp_valid_o), 32'd1);
    repeat (10) begin
      @(negedge Clk);
      check_val("rsp_hold_data", 32'(rsp_data_o), 32'h3C);
      check_val("rsp_hold_valid", 32'(rsp_valid_o), 32'd1);
    end
    @(posedge Clk); #1;
    rsp_ready_i = 1'b1;
    wait_idle(200);

    // mixed random commands queued back to back
    for (int i = 0; i < 6; i++) push_cmd(8'($urandom), 1'($urandom_range(0, 1)));
    wait_idle(3000);

    // fill the FIFO while a slow transmit is in progress
    tx_time = 40;
    push_cmd(8'h11, 1'b0);
    repeat (4) @(negedge Clk);
    for (int i = 0; i < 4; i++) push_cmd(seq[i], 1'b0);
    @(negedge Clk);
    check_val("fifo_full_ready", 32'(cmd_ready_o), 32'd0);
    check_val("fifo_full_busy", 32'(busy_o), 32'd1);
    push_cmd(seq[4], 1'b0);
    wait_idle(3000);
    tx_time = 8;

    // reset while waiting for a byte that never arrives
    loopback = 1'b0;
    push_cmd(8'hC3, 1'b1);
    n = 0;
    while (!m_txdone && n < 500) begin
      @(negedge Clk);
      n++;
    end
    check_val("tx_before_rst", 32'(m_txdone), 32'd1);
    repeat (5) @(negedge Clk);
    #2;
    Rst_n = 1'b0;
    #1;
    check_val("mid_rst_wr", 32'(wr_o), 32'd0);
    check_val("mid_rst_wdata", wdata_o, 32'd0);
    check_val("mid_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check_val("mid_rst_busy", 32'(busy_o), 32'd0);
    check_val("mid_rst_ready", 32'(cmd_ready_o), 32'd1);
    exp_wr.delete();
    exp_rsp.delete();
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(negedge Clk);
      if (rsp_valid_o || busy_o) saw = 1'b1;
    end
    check_val("no_rsp_after_rst", 32'(saw), 32'd0);

`ifdef UART_POLL_TIMEOUT_EN
    // receive never completes: poll limit expires, status cleared, no response
    push_cmd(8'h5A, 1'b1);
    wait_idle(500);
`endif
    loopback = 1'b1;

    // one more round trip after the abandoned command
    push_cmd(8'h96, 1'b1);
    wait_idle(500);

    check_val("timeout_pulses", 32'(tmo_pulses), 32'(EXP_TMO));
    check_val("sb_rsp_empty", 32'(exp_rsp.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
